// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game-of-Life engine.
//   life_state_t     : engine FSM states
//   LFSR_SEED/TAPS   : 16-bit Fibonacci LFSR seed and feedback mask (taps 16,14,13,11)
//   MASK_B3/MASK_S23 : default Conway birth/survive masks
//   nb_dx/nb_dy      : neighbour walk order, offsets encoded 0=-1, 1=0, 2=+1
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_COPY   = 2'd3
    } life_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // bits 15,13,12,10

    localparam logic [8:0]  MASK_B3   = 9'h008;
    localparam logic [8:0]  MASK_S23  = 9'h00C;

    // Neighbours k=0..7: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
    function automatic logic [1:0] nb_dx(input logic [2:0] k);
        case (k)
            3'd0, 3'd3, 3'd5: nb_dx = 2'd0;
            3'd1, 3'd6:       nb_dx = 2'd1;
            default:          nb_dx = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] nb_dy(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: nb_dy = 2'd0;
            3'd3, 3'd4:       nb_dy = 2'd1;
            default:          nb_dy = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/life_lfsr.sv
// life_lfsr: free-running 16-bit Fibonacci LFSR, shifts left every cycle with
// feedback into bit 0; held at LFSR_SEED while rst_n is low (synchronous).
//   clk   : clock
//   rst_n : synchronous active-low reset
//   out   : current LFSR state
module life_lfsr
    import life_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] out
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[14:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign out = r_q;

endmodule

// File: rtl/life_engine.sv
// life_engine: sequential cellular-automaton engine on a 2^LOG_W x 2^LOG_H board.
// Cell address is {y,x}. A step walks every cell (8 neighbour cycles + 1 apply
// cycle) into the next board, then copies next into current one cell per cycle.
// A random fill writes LFSR bit 0 into every cell in ascending order.
//   clk, rst_n                  : clock, synchronous active-low reset (reset starts a fill)
//   step_req, rand_req          : start one generation / random fill (rand wins)
//   birth_mask, survive_mask    : rule masks indexed by neighbour count, latched on accept
//   wrap_en                     : 1 = toroidal edges, 0 = off-board cells are dead
//   wr_en, wr_addr, wr_data     : host cell write, honoured only in IDLE
//   rd_addr, rd_data            : combinational read of the current board
//   busy, done                  : not-IDLE flag, one-cycle pulse on return to IDLE
//   gen_count                   : generations completed since the last fill
//   pop_count                   : live cells, maintained only with LIFE_ENGINE_POPCOUNT_EN
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned LOG_W = 4,
    parameter int unsigned LOG_H = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_req,
    input  logic                   rand_req,
    input  logic [8:0]             birth_mask,
    input  logic [8:0]             survive_mask,
    input  logic                   wrap_en,
    input  logic                   wr_en,
    input  logic [LOG_W+LOG_H-1:0] wr_addr,
    input  logic                   wr_data,
    input  logic [LOG_W+LOG_H-1:0] rd_addr,
    output logic                   rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            gen_count,
    output logic [LOG_W+LOG_H:0]   pop_count
);

    localparam int unsigned AW = LOG_W + LOG_H;
    localparam int unsigned N  = 1 << AW;

    life_state_t   r_state;
    logic [N-1:0]  r_cur;
    logic [N-1:0]  r_next;
    logic [AW-1:0] r_cell;
    logic [3:0]    r_phase;
    logic [3:0]    r_cnt;
    logic [8:0]    r_birth;
    logic [8:0]    r_surv;
    logic          r_wrap;
    logic          r_done;
    logic [15:0]   r_gen;

    logic [15:0]      w_lfsr;
    logic             w_unused_lfsr;
    logic [LOG_W-1:0] w_x;
    logic [LOG_H-1:0] w_y;
    logic [LOG_W-1:0] w_nx;
    logic [LOG_H-1:0] w_ny;
    logic             w_x_oob;
    logic             w_y_oob;
    logic             w_nb_live;
    logic             w_accept;

    life_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .out   (w_lfsr)
    );

    // Only bit 0 feeds the fill.
    assign w_unused_lfsr = ^w_lfsr[15:1];

    assign w_x      = r_cell[LOG_W-1:0];
    assign w_y      = r_cell[AW-1:LOG_W];
    assign w_accept = (r_state == ST_IDLE) && (step_req || rand_req);

    // Neighbour address for the current phase; coordinates wrap naturally and
    // the out-of-board flags suppress the contribution when wrapping is off.
    always_comb begin
        w_nx    = w_x;
        w_ny    = w_y;
        w_x_oob = 1'b0;
        w_y_oob = 1'b0;
        case (nb_dx(r_phase[2:0]))
            2'd0:    begin w_nx = w_x - LOG_W'(1); w_x_oob = (w_x == '0); end
            2'd2:    begin w_nx = w_x + LOG_W'(1); w_x_oob = (&w_x);      end
            default: ;
        endcase
        case (nb_dy(r_phase[2:0]))
            2'd0:    begin w_ny = w_y - LOG_H'(1); w_y_oob = (w_y == '0); end
            2'd2:    begin w_ny = w_y + LOG_H'(1); w_y_oob = (&w_y);      end
            default: ;
        endcase
        w_nb_live = r_cur[{w_ny, w_nx}] & (r_wrap | ~(w_x_oob | w_y_oob));
    end

    // Engine FSM with board storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cell  <= '0;
            r_phase <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_gen   <= '0;
            r_birth <= MASK_B3;
            r_surv  <= MASK_S23;
            r_wrap  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wr_en) begin
                        r_cur[wr_addr] <= wr_data;
                    end
                    if (w_accept) begin
                        r_birth <= birth_mask;
                        r_surv  <= survive_mask;
                        r_wrap  <= wrap_en;
                        r_cell  <= '0;
                        r_phase <= '0;
                        r_cnt   <= '0;
                        r_state <= rand_req ? ST_INIT : ST_UPDATE;
                    end
                end
                ST_INIT: begin
                    r_cur[r_cell] <= w_lfsr[0];
                    r_cell        <= r_cell + AW'(1);
                    if (&r_cell) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_gen   <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (r_phase == 4'd8) begin
                        r_next[r_cell] <= r_cur[r_cell] ? r_surv[r_cnt] : r_birth[r_cnt];
                        r_cnt          <= '0;
                        r_phase        <= '0;
                        r_cell         <= r_cell + AW'(1);
                        if (&r_cell) begin
                            r_state <= ST_COPY;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 4'(w_nb_live);
                        r_phase <= r_phase + 4'd1;
                    end
                end
                ST_COPY: begin
                    r_cur[r_cell] <= r_next[r_cell];
                    r_cell        <= r_cell + AW'(1);
                    if (&r_cell) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_gen   <= r_gen + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LIFE_ENGINE_POPCOUNT_EN
    localparam int unsigned PW = AW + 1;
    logic [PW-1:0] r_pop;

    // Recounted from zero on every fill/step since INIT and COPY rewrite every cell.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_pop <= '0;
        end else if (r_state == ST_INIT) begin
            r_pop <= r_pop + PW'(w_lfsr[0]);
        end else if (r_state == ST_COPY) begin
            r_pop <= r_pop + PW'(r_next[r_cell]);
        end else if (r_state == ST_IDLE && wr_en && (wr_data != r_cur[wr_addr])) begin
            r_pop <= wr_data ? r_pop + PW'(1) : r_pop - PW'(1);
        end
    end

    assign pop_count = r_pop;
`else
    assign pop_count = '0;
`endif

    assign rd_data   = r_cur[rd_addr];
    assign busy      = !rst_n || (r_state != ST_IDLE);
    assign done      = r_done;
    assign gen_count = r_gen;

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter LOG_W, default 4, meaning log2 of board width W.
REQ-002 SHALL have parameter LOG_H, default 4, meaning log2 of board height H.
REQ-003 SHALL define N = 2^(LOG_W+LOG_H) and AW = LOG_W+LOG_H; cell address = {y,x}.
REQ-004 SHALL have port clk  in  1  the single clock.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port step_req  in  1  request one generation.
REQ-007 SHALL have port rand_req  in  1  request an LFSR random fill.
REQ-008 SHALL have port birth_mask  in  9  bit k=1 means a dead cell with k neighbours is born.
REQ-009 SHALL have port survive_mask  in  9  bit k=1 means a live cell with k neighbours survives.
REQ-010 SHALL have port wrap_en  in  1  1=toroidal edges, 0=off-board neighbours count as dead.
REQ-011 SHALL have ports wr_en  in  1, wr_addr  in  AW, wr_data  in  1 for a host cell write.
REQ-012 SHALL have ports rd_addr  in  AW and rd_data  out  1 for a combinational read of the current board.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  out  1  single-cycle pulse on return to IDLE.
REQ-015 SHALL have port gen_count  out  16  completed generations since the last fill.
REQ-016 SHALL have port pop_count  out  AW+1  live-cell count (see Configuration).

Function
REQ-017 SHALL implement states IDLE, INIT, UPDATE, COPY, with separate current and next board arrays of N bits each.
REQ-018 SHALL, in IDLE, enter INIT on rand_req; otherwise enter UPDATE on step_req; rand_req wins if both are high.
REQ-019 SHALL latch birth_mask, survive_mask and wrap_en on the accepting edge and hold them constant until IDLE.
REQ-020 SHALL ignore step_req, rand_req and wr_en while busy; no queuing.
REQ-021 SHALL, in IDLE, write wr_data to cell wr_addr on the clk edge where wr_en=1, visible on rd_data the next cycle.
REQ-022 SHALL spend exactly N cycles in INIT, writing the LFSR bit 0 to cells 0..N-1 in ascending order.
REQ-023 SHALL spend exactly 9 cycles per cell in UPDATE: 8 neighbour-accumulate cycles, then 1 apply cycle; 9N cycles in total.
REQ-024 SHALL apply the rule next = cur ? survive_mask[cnt] : birth_mask[cnt], with a 4-bit count cnt in 0..8.
REQ-025 SHALL wrap x modulo W and y modulo H when wrap_en=1, and contribute 0 for out-of-range neighbours when wrap_en=0.
REQ-026 SHALL spend exactly N cycles in COPY, transferring next to current in ascending address order.
REQ-027 SHALL give a step a latency of 10N cycles from the accepting edge to the first IDLE cycle, with done=1 in that cycle.
REQ-028 SHALL increment gen_count when COPY completes, wrapping 0xFFFF to 0, and clear it to 0 when INIT completes.
REQ-029 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; shift left, feedback into bit 0) that advances every cycle.
REQ-030 SHALL return rd_data from the current board at all times, including mid-COPY with mixed generations.

Reset
REQ-031 SHALL, while rst_n=0, set LFSR=16'hACE1, gen_count=0, done=0, all indices and counters to 0, and state=INIT.
REQ-032 SHALL, on rst_n rising, run INIT automatically, with busy=1 for N cycles and then done=1.
REQ-033 SHALL, on reset mid-operation, abandon it immediately; next-array contents are don't-care.
REQ-034 SHALL hold busy=1 while rst_n=0.

Configuration
REQ-035 SHALL define LIFE_ENGINE_POPCOUNT_EN to maintain pop_count: cleared at INIT start, +1 per live cell written in INIT/COPY, adjusted ±1 on host writes that change a cell, and valid in IDLE.
REQ-036 SHALL, without LIFE_ENGINE_POPCOUNT_EN, tie pop_count to 0 and infer no counter logic.

Structure
REQ-037 SHALL place the state enum, LFSR seed and taps, and the default masks B3 (9'h008) and S23 (9'h00C) in package life_pkg.
REQ-038 SHALL implement the LFSR as sub-module life_lfsr (clk, rst_n, out[15:0]).

Verification (LOG_W=LOG_H=4, N=256, masks B3/S23)
REQ-039 SHALL cover: rst_n low 2 cycles -> busy=1 for 256 cycles, done pulse, gen_count=0, cell 0 = bit 0 of 16'hACE1.
REQ-040 SHALL cover: clear board, write blinker at (7,8),(8,8),(9,8), step -> done after 2560 cycles, live = (8,7),(8,8),(8,9), gen_count=1.
REQ-041 SHALL cover: blocks at corners (0,0),(15,0),(0,15),(15,15), step with wrap_en=1 -> unchanged; same board with wrap_en=0 -> all 4 cells dead.
REQ-042 SHALL cover: birth_mask=0, survive_mask=0, step on a random board -> all cells 0, pop_count=0 with macro defined.
REQ-043 SHALL cover: step_req and rand_req high together in IDLE -> INIT (256 cycles), gen_count=0; step_req during busy -> no extra generation.
REQ-044 SHALL cover: rst_n low at UPDATE cycle 1000 -> INIT restarts, LFSR=16'hACE1, and the fill matches the REQ-039 fill bit-exact.
